// File: rtl/i2s_slave_rx.sv
// ---------------------------------------------------------------------------
// i2s_slave_rx : I2S receiver, slave mode, oversampled by the system clock.
//
// The external SCLK, LRCK and SDATA are synchronized into clk. The block
// detects SCLK rising edges and recovers left/right words, MSB first, with
// the standard I2S one-bit delay after each LRCK change. A stereo pair is
// presented with a valid/ready handshake.
//
// Parameters
//   RESOLUTION  audio word width per channel (8..32), default 24
//
// Ports
//   clk         system clock, rising edge, >= 4x SCLK
//   reset       synchronous active-high reset
//   sclk_in     I2S bit clock (async)
//   lrck_in     I2S word select (async), 0 = left, 1 = right
//   sdata_in    I2S serial data (async), MSB first
//   data_out_L  last complete left word
//   data_out_R  last complete right word
//   valid       a stereo pair is held on data_out_L/R
//   ready       consumer accepts the pair
//   overrun     sticky: a completed frame was dropped (cleared by reset)
//   frame_err   one-clk pulse on a short slot (slot checking builds only)
//
// Build option
//   I2S_RX_SLOT_CHECK_EN  defined: a short slot pulses frame_err and drops
//                         the frame. Undefined: frame_err is tied 0 and a
//                         short word is latched left-justified, zero-filled.
// ---------------------------------------------------------------------------
module i2s_slave_rx #(
  parameter int RESOLUTION = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk_in,
  input  logic                  lrck_in,
  input  logic                  sdata_in,
  output logic [RESOLUTION-1:0] data_out_L,
  output logic [RESOLUTION-1:0] data_out_R,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(RESOLUTION + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESOLUTION - 1);
`ifndef I2S_RX_SLOT_CHECK_EN
  localparam logic [CW-1:0] CNT_FULL = CW'(RESOLUTION);
`endif

  typedef enum logic [1:0] {SYNC, DELAY, SHIFT, PAD} state_t;

  // synchronizers
  logic sclk_m_q, sclk_m_d, sclk_s_q, sclk_s_d, sclk_p_q, sclk_p_d;
  logic lrck_m_q, lrck_m_d, lrck_s_q, lrck_s_d;
  logic sdat_m_q, sdat_m_d, sdat_s_q, sdat_s_d;

  // receive datapath
  state_t                state_q, state_d;
  logic                  chan_q, chan_d;          // 0 = left, 1 = right
  logic                  lr_prev_q, lr_prev_d;
  logic [RESOLUTION-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RESOLUTION-1:0] hold_l_q, hold_l_d;
  logic [RESOLUTION-1:0] hold_r_q, hold_r_d;
  logic                  left_done_q, left_done_d; // left latched this frame
  logic                  done_q, done_d;           // frame completed
`ifdef I2S_RX_SLOT_CHECK_EN
  logic                  err_q, err_d;
`endif

  // output side
  logic [RESOLUTION-1:0] dl_q, dl_d, dr_q, dr_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  // per-edge decode
  logic                  rise, change, wrong_dir, short_slot;
  logic                  latch;
  logic [RESOLUTION-1:0] word;

  assign rise       = sclk_s_q & ~sclk_p_q;
  assign change     = rise & (lrck_s_q != lr_prev_q);
  // A change toward the channel we are already in means the next-channel
  // expectation is broken: drop the partial frame.
  assign wrong_dir  = change & (state_q != SYNC) & (lrck_s_q == chan_q);
  // DELAY/SHIFT always hold fewer than RESOLUTION bits, so any change here
  // ends a slot early.
  assign short_slot = change & ((state_q == DELAY) | (state_q == SHIFT));

  always_comb begin
    sclk_m_d = sclk_in;
    sclk_s_d = sclk_m_q;
    sclk_p_d = sclk_s_q;
    lrck_m_d = lrck_in;
    lrck_s_d = lrck_m_q;
    sdat_m_d = sdata_in;
    sdat_s_d = sdat_m_q;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    if (rise) begin
      unique case (state_q)
        SYNC: begin
          if (change && !lrck_s_q) begin
            state_d = DELAY;
            chan_d  = 1'b0;
          end
        end
        DELAY: begin
          if (change) begin
            state_d = DELAY;
            chan_d  = lrck_s_q;
          end else begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (change) begin
            state_d = DELAY;
            chan_d  = lrck_s_q;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PAD;
          end
        end
        PAD: begin
          if (change) begin
            state_d = DELAY;
            chan_d  = lrck_s_q;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM outputs: shift register, word latching, frame completion
  // -------------------------------------------------------------------------
  always_comb begin
    lr_prev_d   = lr_prev_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    left_done_d = left_done_q;
    done_d      = 1'b0;
    latch       = 1'b0;
    word        = '0;
`ifdef I2S_RX_SLOT_CHECK_EN
    err_d       = 1'b0;
`endif
    if (rise) begin
      lr_prev_d = lrck_s_q;
      unique case (state_q)
        DELAY: begin
          if (!change) begin
            // bit after the LRCK change is the MSB
            sh_d  = {{(RESOLUTION-1){1'b0}}, sdat_s_q};
            cnt_d = CW'(1);
          end
        end
        SHIFT: begin
          if (!change) begin
            sh_d  = {sh_q[RESOLUTION-2:0], sdat_s_q};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              latch = 1'b1;
              word  = {sh_q[RESOLUTION-2:0], sdat_s_q};
            end
          end
        end
        default: ;
      endcase

      if (short_slot) begin
`ifdef I2S_RX_SLOT_CHECK_EN
        err_d       = 1'b1;
        left_done_d = 1'b0;
`else
        // captured bits become the top of the word, LSBs zero
        latch = 1'b1;
        word  = sh_q << (CNT_FULL - cnt_q);
`endif
      end

      if (change) begin
        sh_d  = '0;
        cnt_d = '0;
        if (!lrck_s_q) left_done_d = 1'b0;  // a new frame starts at left
      end

      if (wrong_dir) begin
        latch       = 1'b0;
        left_done_d = 1'b0;
      end

      if (latch) begin
        if (!chan_q) begin
          hold_l_d    = word;
          left_done_d = 1'b1;
        end else begin
          hold_r_d    = word;
          done_d      = left_done_q;
          left_done_d = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake: load the pair one clk after completion
  // -------------------------------------------------------------------------
  always_comb begin
    dl_d      = dl_q;
    dr_d      = dr_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (done_q) begin
      // an acceptance on this same edge frees the slot for the new pair
      if (!valid_q || ready) begin
        dl_d    = hold_l_q;
        dr_d    = hold_r_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_m_q    <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_p_q    <= 1'b0;
      lrck_m_q    <= 1'b0;
      lrck_s_q    <= 1'b0;
      sdat_m_q    <= 1'b0;
      sdat_s_q    <= 1'b0;
      state_q     <= SYNC;
      chan_q      <= 1'b0;
      lr_prev_q   <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      left_done_q <= 1'b0;
      done_q      <= 1'b0;
      dl_q        <= '0;
      dr_q        <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef I2S_RX_SLOT_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      sclk_m_q    <= sclk_m_d;
      sclk_s_q    <= sclk_s_d;
      sclk_p_q    <= sclk_p_d;
      lrck_m_q    <= lrck_m_d;
      lrck_s_q    <= lrck_s_d;
      sdat_m_q    <= sdat_m_d;
      sdat_s_q    <= sdat_s_d;
      state_q     <= state_d;
      chan_q      <= chan_d;
      lr_prev_q   <= lr_prev_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      left_done_q <= left_done_d;
      done_q      <= done_d;
      dl_q        <= dl_d;
      dr_q        <= dr_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef I2S_RX_SLOT_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign data_out_L = dl_q;
  assign data_out_R = dr_q;
  assign valid      = valid_q;
  assign overrun    = overrun_q;
`ifdef I2S_RX_SLOT_CHECK_EN
  assign frame_err  = err_q;
`else
  assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_slave_rx : self-checking bench for i2s_slave_rx (RESOLUTION = 24).
// An I2S master is emulated at SCLK = clk/8. Each slot is built from a word:
// slot bit 0 is the LRCK-change bit, bits 1..24 carry the word MSB first,
// remaining bits are random padding. The expected pairs follow directly
// from the words sent.
// ---------------------------------------------------------------------------
module tb_i2s_slave_rx;
  localparam int RES = 24;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           sclk = 1'b0;
  logic           lrck = 1'b1;
  logic           sdata = 1'b0;
  logic [RES-1:0] data_out_L, data_out_R;
  logic           valid;
  logic           ready = 1'b0;
  logic           overrun;
  logic           frame_err;

  int checks = 0;
  int errors = 0;

  i2s_slave_rx #(.RESOLUTION(RES)) dut (
    .clk(clk), .reset(reset), .sclk_in(sclk), .lrck_in(lrck),
    .sdata_in(sdata), .data_out_L(data_out_L), .data_out_R(data_out_R),
    .valid(valid), .ready(ready), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // monitor: accepted pairs, valid-high cycles, frame_err pulses
  logic [RES-1:0] acc_l[$];
  logic [RES-1:0] acc_r[$];
  int vcyc = 0;
  int ferr = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (valid) vcyc++;
      if (frame_err) ferr++;
      if (valid && ready) begin
        acc_l.push_back(data_out_L);
        acc_r.push_back(data_out_R);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    acc_l.delete();
    acc_r.delete();
  endtask

  task automatic send_bit(input logic lr, input logic d);
    @(posedge clk); #1;
    sclk = 1'b0; lrck = lr; sdata = d;
    repeat (3) @(posedge clk);
    #1 sclk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [RES-1:0] w, input int len);
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i <= RES) send_bit(lr, w[RES-i]);
      else send_bit(lr, 1'($urandom));
    end
  endtask

  task automatic send_frame(input logic [RES-1:0] l, input logic [RES-1:0] r, input int len);
    send_slot(1'b0, l, len);
    send_slot(1'b1, r, len);
  endtask

  task automatic preamble();
    repeat (3) send_bit(1'b1, 1'($urandom));
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (data_out_L !== '0) begin errors++; $display("FAIL reset_L got %h exp 0", data_out_L); end
    checks++; if (data_out_R !== '0) begin errors++; $display("FAIL reset_R got %h exp 0", data_out_R); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
  endtask

  task automatic test_basic();
    logic [RES-1:0] exp_l[$];
    logic [RES-1:0] exp_r[$];
    logic [RES-1:0] l, r;
    int v0;
    do_reset();
    ready = 1'b1;
    v0 = vcyc;
    preamble();
    for (int f = 0; f < 5; f++) begin
      if (f == 0) begin l = 24'hA5A5A5; r = 24'h5A5A5A; end
      else begin l = RES'($urandom); r = RES'($urandom); end
      exp_l.push_back(l);
      exp_r.push_back(r);
      send_frame(l, r, 32);
    end
    checks++;
    if (acc_l.size() != exp_l.size()) begin
      errors++; $display("FAIL basic_count got %0d exp %0d", acc_l.size(), exp_l.size());
    end
    checks++;
    if (vcyc - v0 != exp_l.size()) begin
      errors++; $display("FAIL basic_valid_cycles got %0d exp %0d", vcyc - v0, exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < acc_l.size(); i++) begin
      checks++;
      if (acc_l[i] !== exp_l[i] || acc_r[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL basic_pair%0d got %h/%h exp %h/%h", i, acc_l[i], acc_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    ready = 1'b0;
    preamble();
    send_frame(24'h123456, 24'h654321, 32);
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || data_out_L !== 24'h123456 || data_out_R !== 24'h654321 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first got v=%b %h/%h o=%b exp v=1 123456/654321 o=0", valid, data_out_L, data_out_R, overrun);
    end
    send_frame(24'h111111, 24'h222222, 32);
    @(negedge clk);
    checks++;
    if (data_out_L !== 24'h123456 || data_out_R !== 24'h654321) begin
      errors++; $display("FAIL ovr_hold got %h/%h exp 123456/654321", data_out_L, data_out_R);
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid got %b exp 0", valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_same_cycle();
    logic [RES-1:0] al, ar, bl, br;
    al = RES'($urandom); ar = RES'($urandom);
    bl = RES'($urandom); br = RES'($urandom);
    do_reset();
    ready = 1'b0;
    preamble();
    send_frame(al, ar, 32);
    send_slot(1'b0, bl, 32);
    for (int i = 0; i < 32; i++) begin
      if (i == RES) begin
        // last right bit: SCLK rise, 2 sync flops, edge detect, word latch,
        // then the pair loads one clk later -- ready is high on that edge
        @(posedge clk); #1;
        sclk = 1'b0; lrck = 1'b1; sdata = br[0];
        repeat (3) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data_out_L !== al || data_out_R !== ar) begin
          errors++; $display("FAIL same_before got v=%b %h/%h exp v=1 %h/%h", valid, data_out_L, data_out_R, al, ar);
        end
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data_out_L !== bl || data_out_R !== br) begin
          errors++; $display("FAIL same_load got v=%b %h/%h exp v=1 %h/%h", valid, data_out_L, data_out_R, bl, br);
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same_overrun got %b exp 0", overrun); end
      end else if (i >= 1 && i <= RES) begin
        send_bit(1'b1, br[RES-i]);
      end else begin
        send_bit(1'b1, 1'($urandom));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [RES-1:0] yl, zl, zr;
    int v0;
    yl = RES'($urandom); zl = RES'($urandom); zr = RES'($urandom);
    do_reset();
    ready = 1'b1;
    preamble();
    send_frame(RES'($urandom), RES'($urandom), 32);
    for (int i = 0; i < 10; i++) send_bit(1'b0, (i >= 1) ? yl[RES-i] : 1'b0);
    do_reset();
    @(negedge clk);
    checks++;
    if (data_out_L !== '0 || data_out_R !== '0 || valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rmid_clear got %h/%h v=%b o=%b exp 0/0 v=0 o=0", data_out_L, data_out_R, valid, overrun);
    end
    v0 = vcyc;
    for (int i = 10; i < 32; i++) send_bit(1'b0, (i <= RES) ? yl[RES-i] : 1'b0);
    send_slot(1'b1, RES'($urandom), 32);
    checks++; if (vcyc != v0) begin errors++; $display("FAIL rmid_partial got %0d valid cycles exp 0", vcyc - v0); end
    send_frame(zl, zr, 32);
    checks++;
    if (acc_l.size() != 1) begin
      errors++; $display("FAIL rmid_count got %0d exp 1", acc_l.size());
    end else if (acc_l[0] !== zl || acc_r[0] !== zr) begin
      errors++; $display("FAIL rmid_pair got %h/%h exp %h/%h", acc_l[0], acc_r[0], zl, zr);
    end
  endtask

  task automatic test_right_start();
    logic [RES-1:0] pl, pr;
    int v0;
    pl = RES'($urandom); pr = RES'($urandom);
    do_reset();
    ready = 1'b1;
    v0 = vcyc;
    send_slot(1'b1, RES'($urandom), 32);
    checks++; if (vcyc != v0) begin errors++; $display("FAIL rstart_early got %0d valid cycles exp 0", vcyc - v0); end
    send_frame(pl, pr, 32);
    checks++;
    if (acc_l.size() != 1) begin
      errors++; $display("FAIL rstart_count got %0d exp 1", acc_l.size());
    end else if (acc_l[0] !== pl || acc_r[0] !== pr) begin
      errors++; $display("FAIL rstart_pair got %h/%h exp %h/%h", acc_l[0], acc_r[0], pl, pr);
    end
  endtask

  task automatic test_short_slot();
    int v0, f0;
    do_reset();
    ready = 1'b1;
    preamble();
    v0 = vcyc;
    f0 = ferr;
    // change bit plus 16 captured bits per slot
    send_slot(1'b0, 24'hFFFFFF, 17);
    send_slot(1'b1, 24'hFFFFFF, 17);
    send_bit(1'b0, 1'b0);
    repeat (4) @(posedge clk);
`ifdef I2S_RX_SLOT_CHECK_EN
    checks++; if (ferr - f0 != 2) begin errors++; $display("FAIL short_frame_err got %0d pulses exp 2", ferr - f0); end
    checks++; if (vcyc != v0) begin errors++; $display("FAIL short_no_valid got %0d valid cycles exp 0", vcyc - v0); end
`else
    checks++; if (ferr != f0) begin errors++; $display("FAIL short_frame_err got %0d pulses exp 0", ferr - f0); end
    checks++;
    if (acc_l.size() != 1) begin
      errors++; $display("FAIL short_count got %0d exp 1", acc_l.size());
    end else if (acc_l[0] !== 24'hFFFF00 || acc_r[0] !== 24'hFFFF00) begin
      errors++; $display("FAIL short_pair got %h/%h exp ffff00/ffff00", acc_l[0], acc_r[0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_right_start();
    test_short_slot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_slave_rx.md
I2S_SLAVE_RX -- requirements
Module: i2s_slave_rx

Interface
REQ-001 The block SHALL have parameter RESOLUTION, default 24, giving the audio word width in bits per channel (valid range 8..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active; it SHALL be at least 4x the SCLK frequency.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sclk_in, input, 1 bit: external I2S bit clock (asynchronous to clk).
REQ-005 The block SHALL have port lrck_in, input, 1 bit: external word select (asynchronous); 0 = left, 1 = right.
REQ-006 The block SHALL have port sdata_in, input, 1 bit: external serial data, MSB first (asynchronous).
REQ-007 The block SHALL have port data_out_L, output, RESOLUTION bits: last complete left word.
REQ-008 The block SHALL have port data_out_R, output, RESOLUTION bits: last complete right word.
REQ-009 The block SHALL have port valid, output, 1 bit: a stereo pair is held on data_out_L and data_out_R.
REQ-010 The block SHALL have port ready, input, 1 bit: the consumer accepts the pair.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag; a frame was dropped.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-clk pulse on a short slot (see Configuration).

Function
REQ-013 sclk_in, lrck_in and sdata_in SHALL each pass through 2 flops into clk; a third register SHALL hold the previous synchronized sclk for edge detection.
REQ-014 An SCLK rising edge SHALL be the clk cycle where synchronized sclk = 1 and previous = 0; all sampling SHALL occur only on such cycles.
REQ-015 On each SCLK rising edge, the block SHALL sample lrck and sdata and register the sampled lrck as lr_prev.
REQ-016 A "change edge" SHALL be an SCLK rising edge where sampled lrck differs from lr_prev.
REQ-017 The state machine SHALL have states SYNC, DELAY, SHIFT and PAD.
REQ-018 SYNC -> DELAY SHALL occur on a change edge where lrck goes 1->0 (start of left); all other edges SHALL be ignored in SYNC.
REQ-019 DELAY -> SHIFT SHALL occur on the next SCLK rising edge; that bit SHALL be captured as the MSB (I2S one-bit delay) and the bit count SHALL be set to 1.
REQ-020 In SHIFT, each SCLK rising edge SHALL shift sdata into the channel shift register MSB-first; at count = RESOLUTION the word SHALL be latched to the channel holding register and the state SHALL go to PAD.
REQ-021 In PAD, bits SHALL be discarded; a change edge SHALL go to DELAY for the opposite channel.
REQ-022 A change edge in SHIFT, or in DELAY, with fewer than RESOLUTION bits captured SHALL be a short slot; the change-edge bit SHALL NOT be captured.
REQ-023 A change edge in the wrong direction (1->0 while expecting right, or the reverse) SHALL discard the partial frame and go to DELAY for the channel now indicated.
REQ-024 Frame completion SHALL be latching the right word after a left word latched in the same frame; 1 clk later, data_out_L/R SHALL be updated and valid SHALL assert.
REQ-025 valid SHALL remain high, with data_out_L/R stable, until a clk edge with valid & ready; valid SHALL deassert on that edge.
REQ-026 If a frame completes while valid & !ready, the new pair SHALL be dropped, the outputs SHALL be kept, and overrun SHALL be set.
REQ-027 On the same-cycle case (ready accepted on the same edge as completion), the new pair SHALL be loaded, valid SHALL stay high, and no overrun SHALL be set.
REQ-028 overrun SHALL clear only on reset.

Reset
REQ-029 On reset = 1 at a clk edge: state SHALL go to SYNC; data_out_L, data_out_R, shift registers, bit count and lr_prev SHALL be 0; valid, overrun and frame_err SHALL be 0; synchronizer flops SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first pair after reset SHALL come from the first full frame starting at a 1->0 lrck change.

Configuration
REQ-031 The macro I2S_RX_SLOT_CHECK_EN SHALL control short-slot handling.
REQ-032 With I2S_RX_SLOT_CHECK_EN defined, a short slot SHALL pulse frame_err for 1 clk and discard the current frame; no valid SHALL be raised for that frame.
REQ-033 Without I2S_RX_SLOT_CHECK_EN, frame_err SHALL be tied 0, and a short-slot word SHALL be latched left-justified with the missing LSBs zero-filled; the frame SHALL then continue normally.

Verification
REQ-034 Reset, then 32-bit slots, L=0xA5A5A5, R=0x5A5A5A, ready=1 -> valid pulses 1 clk per frame; data_out_L=0xA5A5A5, data_out_R=0x5A5A5A.
REQ-035 ready=0 for 2 frames (L=0x123456, R=0x654321, then L=0x111111, R=0x222222) -> outputs stay 0x123456/0x654321, overrun=1; after ready=1, valid drops.
REQ-036 Reset asserted mid-left-slot -> all outputs 0; next partial frame ignored; first valid carries the first full frame's data.
REQ-037 16-bit slots with RESOLUTION=24, L=0xFFFF... -> with macro: frame_err pulses and no valid; without macro: data_out_L=0xFFFF00.
REQ-038 ready asserted on the completion edge of the next frame -> new pair loaded, valid stays 1, overrun=0.
REQ-039 Stream starting with lrck=1 (right) -> no valid until after the first 1->0 change edge plus one full frame.
